// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host scan-code receiver: input conditioning, frame FSM with
// timeout, optional E0/F0 prefix folding and a show-ahead FIFO.
module ps2_scancode_rx #(
    parameter int DEPTH_LOG2   = 3,
    parameter int FILT_LEN     = 4,
    parameter int TIMEOUT_CYC  = 50000,
    parameter bit MERGE_PREFIX = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ps2_clk,
    input  logic                  ps2_data,
    input  logic                  ready,
    input  logic                  err_clr,
    output logic [7:0]            data,
    output logic                  ext,
    output logic                  brk,
    output logic                  valid,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic                  err_parity,
    output logic                  err_stop,
    output logic                  err_timeout,
    output logic [1:0]            fsm_state
);

    localparam int AW    = DEPTH_LOG2;
    localparam int DEPTH = 1 << AW;
    localparam int TW    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [AW:0] LVL_ONE = (AW+1)'(1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    logic [1:0]          clk_sync;
    logic [1:0]          dat_sync;
    logic [FILT_LEN-1:0] hist;
    logic                filt_q;
    logic                filt_d;
    logic                samp;
    logic                samp_data;

    state_t              state_q;
    state_t              state_d;
    logic                start_bit;
    logic                data_bit;
    logic                par_bit;
    logic                stop_bit;
    logic [2:0]          bitcnt;
    logic [7:0]          shreg;
    logic                par_acc;
    logic                done_q;
    logic                done_stop;
    logic                done_par;
    logic [TW-1:0]       tmo_cnt;
    logic                timeout;

    logic                frame_ok;
    logic                is_e0;
    logic                is_f0;
    logic                prefix;
    logic                push_req;
    logic [9:0]          push_entry;
    logic                pend_ext;
    logic                pend_brk;

    logic [9:0]          mem [DEPTH];
    logic [AW:0]         w_ptr;
    logic [AW:0]         r_ptr;
    logic [AW:0]         level_q;
    logic [9:0]          head;
    logic                pop;
    logic                push;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= 2'b11;
            dat_sync  <= 2'b11;
            hist      <= '1;
            filt_q    <= 1'b1;
            samp      <= 1'b0;
            samp_data <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            dat_sync  <= {dat_sync[0], ps2_data};
            hist      <= {hist[FILT_LEN-2:0], clk_sync[1]};
            filt_q    <= filt_d;
            samp      <= filt_q & ~filt_d;
            samp_data <= dat_sync[1];
        end
    end

    // Filtered clock only moves once the whole history window agrees.
    always_comb begin
        filt_d = filt_q;
        if (&hist)
            filt_d = 1'b1;
        else if (~|hist)
            filt_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (samp && !samp_data)     state_d = S_DATA;
            S_DATA:   if (samp && bitcnt == 3'd7) state_d = S_PARITY;
            S_PARITY: if (samp)                   state_d = S_STOP;
            S_STOP:   if (samp)                   state_d = S_IDLE;
            default:                              state_d = S_IDLE;
        endcase
        if (timeout)
            state_d = S_IDLE;
    end

    always_comb begin
        start_bit = 1'b0;
        data_bit  = 1'b0;
        par_bit   = 1'b0;
        stop_bit  = 1'b0;
        case (state_q)
            S_IDLE:   start_bit = samp & ~samp_data;
            S_DATA:   data_bit  = samp;
            S_PARITY: par_bit   = samp;
            S_STOP:   stop_bit  = samp;
            default:  ;
        endcase
    end

    assign fsm_state = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitcnt    <= 3'd0;
            shreg     <= 8'd0;
            par_acc   <= 1'b0;
            done_q    <= 1'b0;
            done_stop <= 1'b0;
            done_par  <= 1'b0;
        end else begin
            done_q <= stop_bit;
            if (start_bit) begin
                bitcnt  <= 3'd0;
                par_acc <= 1'b0;
            end
            if (data_bit) begin
                shreg[bitcnt] <= samp_data;
                par_acc       <= par_acc ^ samp_data;
                bitcnt        <= bitcnt + 3'd1;
            end
            if (par_bit)
                par_acc <= par_acc ^ samp_data;
            if (stop_bit) begin
                done_stop <= samp_data;
                done_par  <= par_acc;
            end
        end
    end

    // A samp arriving on the limit cycle wins over the timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tmo_cnt <= '0;
        else if (state_q == S_IDLE || samp)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + TW'(1);
    end

    assign timeout = (state_q != S_IDLE) && !samp && (tmo_cnt == TMO_LAST);

    assign frame_ok = done_q & done_stop & done_par;
    assign is_e0    = (shreg == 8'hE0);
    assign is_f0    = (shreg == 8'hF0);
    assign prefix   = MERGE_PREFIX && (is_e0 || is_f0);
    assign push_req = frame_ok & ~prefix;

    always_comb begin
        push_entry = {2'b00, shreg};
        if (MERGE_PREFIX)
            push_entry = {pend_ext, pend_brk, shreg};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_ext <= 1'b0;
            pend_brk <= 1'b0;
        end else if (timeout || (done_q && !frame_ok) || push_req) begin
            pend_ext <= 1'b0;
            pend_brk <= 1'b0;
        end else if (frame_ok && prefix) begin
            if (is_e0)
                pend_ext <= 1'b1;
            else
                pend_brk <= 1'b1;
        end
    end

    // valid/ready: the head entry moves to the consumer on every cycle with
    // valid && ready; valid never depends on ready.
    assign empty = (w_ptr == r_ptr);
    assign full  = (w_ptr[AW] != r_ptr[AW]) && (w_ptr[AW-1:0] == r_ptr[AW-1:0]);
    assign valid = ~empty;
    assign pop   = valid & ready;
    assign push  = push_req & (~full | pop);

    always_ff @(posedge clk) begin
        if (push)
            mem[w_ptr[AW-1:0]] <= push_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_ptr    <= '0;
            r_ptr    <= '0;
            level_q  <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= push_req & full & ~pop;
            if (push)
                w_ptr <= w_ptr + LVL_ONE;
            if (pop)
                r_ptr <= r_ptr + LVL_ONE;
            case ({push, pop})
                2'b10:   level_q <= level_q + LVL_ONE;
                2'b01:   level_q <= level_q - LVL_ONE;
                default: level_q <= level_q;
            endcase
        end
    end

    assign level = level_q;
    assign head  = mem[r_ptr[AW-1:0]];
    assign data  = empty ? 8'd0 : head[7:0];
    assign brk   = empty ? 1'b0 : head[8];
    assign ext   = empty ? 1'b0 : head[9];

    // Set beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_parity  <= 1'b0;
            err_stop    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            if (done_q && !done_par)
                err_parity <= 1'b1;
            else if (err_clr)
                err_parity <= 1'b0;
            if (done_q && !done_stop)
                err_stop <= 1'b1;
            else if (err_clr)
                err_stop <= 1'b0;
            if (timeout)
                err_timeout <= 1'b1;
            else if (err_clr)
                err_timeout <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Bench for ps2_scancode_rx: PS/2 frames driven from tasks, results checked
// against a queue-based model of the receiver's byte-level behaviour.
module tb_ps2_scancode_rx;
    localparam int F     = 4;
    localparam int TMO   = 500;
    localparam int H     = 20;
    localparam int DL    = 3;
    localparam int DEPTH = 1 << DL;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic pc = 1'b1, pd = 1'b1, ready = 1'b0, err_clr = 1'b0;
    logic [7:0] data;
    logic ext, brk, valid, empty, full, overflow, err_parity, err_stop, err_timeout;
    logic [DL:0] level;
    logic [1:0] fsm_state;

    logic pc_r = 1'b1, pd_r = 1'b1, ready_r = 1'b0, err_clr_r = 1'b0;
    logic [7:0] data_r;
    logic ext_r, brk_r, valid_r, empty_r, full_r, overflow_r, err_parity_r, err_stop_r, err_timeout_r;
    logic [DL:0] level_r;
    logic [1:0] fsm_state_r;

    ps2_scancode_rx #(.DEPTH_LOG2(DL), .FILT_LEN(F), .TIMEOUT_CYC(TMO), .MERGE_PREFIX(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .ps2_clk(pc), .ps2_data(pd), .ready(ready), .err_clr(err_clr),
        .data(data), .ext(ext), .brk(brk), .valid(valid), .empty(empty), .full(full), .level(level),
        .overflow(overflow), .err_parity(err_parity), .err_stop(err_stop), .err_timeout(err_timeout),
        .fsm_state(fsm_state)
    );

    ps2_scancode_rx #(.DEPTH_LOG2(DL), .FILT_LEN(F), .TIMEOUT_CYC(TMO), .MERGE_PREFIX(1'b0)) dut_raw (
        .clk(clk), .rst_n(rst_n), .ps2_clk(pc_r), .ps2_data(pd_r), .ready(ready_r), .err_clr(err_clr_r),
        .data(data_r), .ext(ext_r), .brk(brk_r), .valid(valid_r), .empty(empty_r), .full(full_r),
        .level(level_r), .overflow(overflow_r), .err_parity(err_parity_r), .err_stop(err_stop_r),
        .err_timeout(err_timeout_r), .fsm_state(fsm_state_r)
    );

    int n_tests = 0;
    int n_fail = 0;
    int ovf_seen = 0;
    int exp_ovf = 0;
    logic [9:0] exp_q[$];
    bit e_par = 0, e_stop = 0, e_tmo = 0, pend_e = 0, pend_b = 0;

    always @(negedge clk) if (overflow === 1'b1) ovf_seen++;

    initial begin
        #5ms;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        logic [9:0] hd;
        check({tag, "/level"}, 32'(level), 32'(exp_q.size()));
        check({tag, "/valid"}, 32'(valid), 32'(exp_q.size() != 0));
        check({tag, "/empty"}, 32'(empty), 32'(exp_q.size() == 0));
        check({tag, "/full"}, 32'(full), 32'(exp_q.size() == DEPTH));
        if (exp_q.size() != 0) begin
            hd = exp_q[0];
            check({tag, "/head"}, 32'({ext, brk, data}), 32'(hd));
        end
        check({tag, "/errs"}, 32'({err_parity, err_stop, err_timeout}), 32'({e_par, e_stop, e_tmo}));
        check({tag, "/ovf"}, 32'(ovf_seen), 32'(exp_ovf));
    endtask

    task automatic drive_clk(input bit to_raw, input logic v);
        if (to_raw) pc_r = v; else pc = v;
    endtask

    task automatic drive_dat(input bit to_raw, input logic v);
        if (to_raw) pd_r = v; else pd = v;
    endtask

    // mode: 0 plain, 1 pulse ready in the commit cycle, 2 pulse err_clr in the commit cycle
    task automatic send_frame(input logic [7:0] b, input bit par_bad, input bit stop_bad,
                              input int nbits, input bit glitch, input int mode, input bit to_raw);
        logic [10:0] f;
        f = {~stop_bad, (~^b) ^ par_bad, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            drive_dat(to_raw, f[i]);
            if (glitch && i == 4) begin
                repeat (H/2) @(negedge clk);
                drive_clk(to_raw, 1'b0);
                repeat (2) @(negedge clk);
                drive_clk(to_raw, 1'b1);
                repeat (H - H/2 - 2) @(negedge clk);
            end else begin
                repeat (H) @(negedge clk);
            end
            drive_clk(to_raw, 1'b0);
            if (mode != 0 && i == 10) begin
                repeat (F + 4) @(posedge clk);
                @(negedge clk);
                if (mode == 1) ready = 1'b1; else err_clr = 1'b1;
                @(negedge clk);
                ready = 1'b0;
                err_clr = 1'b0;
                repeat (H - F - 5) @(negedge clk);
            end else begin
                repeat (H) @(negedge clk);
            end
            drive_clk(to_raw, 1'b1);
        end
        drive_dat(to_raw, 1'b1);
        repeat (H) @(negedge clk);
        if (!to_raw) begin
            if (nbits < 11) begin
                e_tmo = 1; pend_e = 0; pend_b = 0;
            end else begin
                if (mode == 1 && exp_q.size() > 0) void'(exp_q.pop_front());
                if (mode == 2) begin e_par = 0; e_stop = 0; e_tmo = 0; end
                if (stop_bad || par_bad) begin
                    if (stop_bad) e_stop = 1;
                    if (par_bad) e_par = 1;
                    pend_e = 0; pend_b = 0;
                end else if (b == 8'hE0) begin
                    pend_e = 1;
                end else if (b == 8'hF0) begin
                    pend_b = 1;
                end else begin
                    if (exp_q.size() < DEPTH) exp_q.push_back({pend_e, pend_b, b});
                    else exp_ovf++;
                    pend_e = 0; pend_b = 0;
                end
            end
        end
    endtask

    task automatic good(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0, 11, 1'b0, 0, 1'b0);
    endtask

    task automatic pop_one();
        @(negedge clk) ready = 1'b1;
        @(negedge clk) ready = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
    endtask

    task automatic pop_raw();
        @(negedge clk) ready_r = 1'b1;
        @(negedge clk) ready_r = 1'b0;
    endtask

    task automatic clr_errs();
        @(negedge clk) err_clr = 1'b1;
        @(negedge clk) err_clr = 1'b0;
        e_par = 0; e_stop = 0; e_tmo = 0;
    endtask

    initial begin
        logic [7:0] rb;
        int n;
        repeat (5) @(negedge clk);
        check("rst/valid", 32'(valid), 0);
        check("rst/empty", 32'(empty), 1);
        check("rst/full", 32'(full), 0);
        check("rst/level", 32'(level), 0);
        check("rst/head", 32'({ext, brk, data}), 0);
        check("rst/errs", 32'({err_parity, err_stop, err_timeout, overflow}), 0);
        check("rst/fsm", 32'(fsm_state), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // single good frame
        good(8'h1C);
        check_state("t1");
        check("t1/data", 32'(data), 32'h1C);
        pop_one();
        check_state("t1pop");

        // prefix folding, then the raw instance
        good(8'hE0); good(8'hF0); good(8'h75);
        check_state("t2");
        check("t2/entry", 32'({ext, brk, data, level}), 32'({2'b11, 8'h75, 4'd1}));
        pop_one();
        send_frame(8'hE0, 0, 0, 11, 0, 0, 1'b1);
        send_frame(8'hF0, 0, 0, 11, 0, 0, 1'b1);
        send_frame(8'h75, 0, 0, 11, 0, 0, 1'b1);
        check("t2raw/level", 32'(level_r), 3);
        check("t2raw/h0", 32'({ext_r, brk_r, data_r}), 32'h0E0);
        pop_raw();
        check("t2raw/h1", 32'({ext_r, brk_r, data_r}), 32'h0F0);
        pop_raw();
        check("t2raw/h2", 32'({ext_r, brk_r, data_r}), 32'h075);
        pop_raw();
        check("t2raw/end", 32'({valid_r, empty_r, full_r, overflow_r, fsm_state_r, level_r}),
              32'({1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0}));
        check("t2raw/errs", 32'({err_parity_r, err_stop_r, err_timeout_r}), 0);

        // parity error, stop error, clear, and set-beats-clear
        send_frame(8'h1C, 1'b1, 1'b0, 11, 0, 0, 1'b0);
        check_state("t3par");
        send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b1, 11, 0, 0, 1'b0);
        check_state("t3stop");
        send_frame(8'h33, 1'b1, 1'b0, 11, 0, 2, 1'b0);
        check_state("t3setclr");
        clr_errs();
        check_state("t3clr");

        // overflow, drain, then push with a same-cycle pop at full
        for (int i = 1; i <= 9; i++) good(8'(i));
        check_state("t4full");
        check("t4/head", 32'(data), 32'h01);
        while (exp_q.size() > 0) begin
            pop_one();
            check_state("t4drain");
        end
        for (int i = 1; i <= 8; i++) good(8'(i));
        send_frame(8'h09, 0, 0, 11, 0, 1, 1'b0);
        check_state("t4pp");
        while (exp_q.size() > 0) begin
            pop_one();
            check_state("t4drain2");
        end

        // timeout mid-frame after a pending E0
        good(8'hE0);
        send_frame(8'h5A, 0, 0, 6, 0, 0, 1'b0);
        check("t5/fsm_mid", 32'(fsm_state), 1);
        repeat (TMO + 50) @(negedge clk);
        check("t5/fsm_idle", 32'(fsm_state), 0);
        check_state("t5tmo");
        good(8'h2A);
        check_state("t5next");
        pop_one();
        clr_errs();

        // short clock glitch mid-frame
        rb = 8'($urandom_range(0, 255));
        if (rb == 8'hE0 || rb == 8'hF0) rb = 8'h3C;
        send_frame(rb, 0, 0, 11, 1'b1, 0, 1'b0);
        check_state("t6");
        pop_one();

        // randomized traffic
        for (int it = 0; it < 40; it++) begin
            rb = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) rb = $urandom_range(0, 1) ? 8'hE0 : 8'hF0;
            send_frame(rb, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, 11,
                       $urandom_range(0, 5) == 0, 0, 1'b0);
            check_state("rnd");
            n = $urandom_range(0, 2);
            for (int k = 0; k < n; k++)
                if (exp_q.size() > 0) pop_one();
            if ($urandom_range(0, 4) == 0) clr_errs();
            check_state("rndpop");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ps2_scancode_rx.md
# ps2_scancode_rx

Parametrised PS/2 device-to-host receiver that sits between the PS/2 keyboard pins and the keyboard/MMIO register interface. It has the following features:
- Digital glitch filter on `ps2_clk`.
- Per-frame inter-bit timeout.
- Sticky, clearable error flags.
- Optional folding of the 0xE0 (extended) and 0xF0 (break) prefixes into tag bits.
- Show-ahead FIFO of configurable depth with valid/ready pop handshake.

## Interface
Parameters:
- `DEPTH_LOG2`, default 3: the FIFO holds 2^DEPTH_LOG2 entries.
- `FILT_LEN`, default 4: number of consecutive equal synchronised samples required before the filtered `ps2_clk` changes. Range 2..15.
- `TIMEOUT_CYC`, default 50000: maximum `clk` cycles allowed between sample pulses inside a frame.
- `MERGE_PREFIX`, default 1: 1 folds E0/F0 into `ext`/`brk`; 0 pushes every byte raw.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `ps2_clk` in 1: raw PS/2 clock, asynchronous to `clk`.
- `ps2_data` in 1: raw PS/2 data, asynchronous to `clk`.
- `ready` in 1: consumer accepts the head entry this cycle.
- `err_clr` in 1: clears all sticky error flags.
- `data` out 8: head entry scan code.
- `ext` out 1: head entry was preceded by E0.
- `brk` out 1: head entry was preceded by F0.
- `valid` out 1: FIFO is not empty.
- `empty` out 1: FIFO is empty.
- `full` out 1: FIFO is full.
- `level` out DEPTH_LOG2+1: current number of entries.
- `overflow` out 1: one-cycle pulse when a good byte is dropped because the FIFO is full.
- `err_parity` out 1: sticky parity error.
- `err_stop` out 1: sticky stop-bit error.
- `err_timeout` out 1: sticky timeout error.

## Operation
Input conditioning:
- `ps2_clk` and `ps2_data` each pass through a 2-FF synchroniser.
- The filtered clock takes the synchronised value once the last FILT_LEN synchronised samples agree. Otherwise it holds.
- A falling edge of the filtered clock produces a registered 1-cycle `samp` pulse. The synchronised `ps2_data` is captured on that same cycle.

Frame FSM (IDLE, DATA, PARITY, STOP), advancing only on `samp`:
- IDLE, `samp` with data=0: go to DATA, clear bit counter and parity accumulator.
- IDLE, `samp` with data=1: stay in IDLE. This is not an error.
- DATA: shift the bit into buffer position `bitcnt` (LSB first) and XOR it into the accumulator. After bit 7, go to PARITY.
- PARITY: XOR the bit into the accumulator, then go to STOP. A good frame has accumulator = 1 (odd parity over the 8 data bits plus the parity bit).
- STOP: always return to IDLE, then classify the frame:
  - Stop bit = 0: set `err_stop`. No push.
  - Stop bit = 1 and parity bad: set `err_parity`. No push.
  - Both good: commit the byte.
  - If both checks fail, both flags are set.

Timeout:
- The counter runs in any state other than IDLE and is cleared by each `samp`.
- On reaching TIMEOUT_CYC-1: set `err_timeout`, abort to IDLE, discard the partial byte.

Prefix merge (MERGE_PREFIX=1):
- A committed E0 sets `pend_ext`. A committed F0 sets `pend_brk`. Neither is pushed.
- Any other committed byte pushes {`pend_ext`, `pend_brk`, byte} and clears both pending flags.
- Any error frame or timeout clears both pending flags.
- With MERGE_PREFIX=0, every committed byte is pushed with `ext`=`brk`=0.

FIFO:
- 10-bit entries; read/write pointers are DEPTH_LOG2+1 bits wide.
- `empty` = pointers equal. `full` = MSBs differ and the low bits are equal.
- Show-ahead: `data`/`ext`/`brk` always present the head entry and are don't-care when `empty`.
- Pop when `valid && ready`.
- A push is accepted if `!full` or a pop occurs in the same cycle.
- Otherwise the entry is dropped, `overflow` pulses for 1 cycle, and pending flags clear.
- `level` tracks push/pop, including a simultaneous push+pop, which leaves `level` unchanged.

Error flags:
- Sticky until `err_clr`.
- If a set and `err_clr` occur in the same cycle, the set wins.
- `err_clr` has no effect on the FSM or FIFO.

## Timing
- Reset (async assert, sync release) drives:
  - FSM to IDLE.
  - Pointers, `level`, pending flags, error flags and `overflow` to 0.
  - `data`/`ext`/`brk` to 0, `valid`=0, `empty`=1, `full`=0.
- Asserting reset mid-frame aborts the frame with no flag set.
- Filter/sync latency: the `samp` pulse occurs FILT_LEN+3 cycles after a clean `ps2_clk` falling edge, and is constant.
- Commit occurs on the cycle after the STOP-state `samp`. The FIFO write occurs on the following edge.
- `valid` rises at most FILT_LEN+6 cycles after the stop-bit falling edge.
- Pop: `r_ptr` advances on the clock edge where `valid && ready`. The new head is visible the next cycle.
- `ps2_clk` low or high pulses shorter than FILT_LEN cycles produce no `samp`.
- The PS/2 bit period (≥60 µs) must be much longer than FILT_LEN+3 cycles. The integrator guarantees this.

## Test plan
1. Frame 0x1C with good parity (P=0) and stop -> one entry: `data`=0x1C, `ext`=0, `brk`=0, `level`=1. Pulse `ready` -> `empty`=1.
2. Frames E0, F0, 0x75 with MERGE_PREFIX=1 -> exactly one entry: `data`=0x75, `ext`=1, `brk`=1. Repeat with MERGE_PREFIX=0 -> three entries E0, F0, 75, all tags 0.
3. Frame 0x1C with the parity bit inverted -> no push, `err_parity`=1. Next frame with stop=0 -> `err_stop`=1. Pulse `err_clr` -> both flags 0.
4. Nine good frames (0x01..0x09) with `ready`=0 at DEPTH_LOG2=3:
   - `full`=1, `level`=8, `overflow` pulses once, and the head is 0x01.
   - Repeat with `ready`=1 on the cycle the 9th push commits -> `level` stays 8 and 0x09 is stored.
5. Start bit plus 5 data bits, then silence for TIMEOUT_CYC cycles -> `err_timeout`=1 and FSM back in IDLE. A following good 0x2A frame -> `data`=0x2A.
6. A 2-cycle `ps2_clk` low glitch (FILT_LEN=4) injected mid-frame -> ignored. The byte is received intact with no error flags set.
